am_ask_modulator: RTL and testbench

AM_ASK_MODULATOR -- requirements
Module: am_ask_modulator

---
 rtl/am_ask_modulator_pkg.sv | 32 +++
 rtl/am_ask_modulator_symgen.sv | 42 ++++
 rtl/am_ask_modulator.sv | 105 ++++++++++
 tb/tb_am_ask_modulator.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/am_ask_modulator_pkg.sv
// Shared constants and helpers for the AM/ASK modulator: mode encoding,
// PRBS7 generator definition and offset-binary / clipping helpers.
package am_ask_modulator_pkg;

  typedef enum logic [1:0] {
    MODE_AM   = 2'd0,
    MODE_ASK  = 2'd1,
    MODE_PASS = 2'd2,
    MODE_MUTE = 2'd3
  } mode_e;

  // PRBS7 x^7 + x^6 + 1, shifted towards the MSB
  localparam logic [6:0] PRBS7_SEED  = 7'h7F;
  localparam int         PRBS7_TAP_A = 6;
  localparam int         PRBS7_TAP_B = 5;

  function automatic logic [63:0] midscale(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

  function automatic logic signed [63:0] clip_s(input logic signed [63:0] v,
                                                input int unsigned        w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/am_ask_modulator_symgen.sv
// Symbol timer plus PRBS7 data source; the LFSR steps once per symbol boundary.
module ask_symbol_gen
  import am_ask_modulator_pkg::*;
#(
  parameter int unsigned SYM_DIV = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sym_en_i,
  output logic sym_bit_o,
  output logic sym_strobe_o
);

  localparam logic [31:0] LAST = 32'(SYM_DIV - 1);

  logic [31:0] cnt_q;
  logic [6:0]  lfsr_q;
  logic        strobe_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      lfsr_q   <= PRBS7_SEED;
      strobe_q <= 1'b0;
    end else if (sym_en_i) begin
      if (cnt_q == LAST) begin
        cnt_q    <= '0;
        lfsr_q   <= {lfsr_q[5:0], lfsr_q[PRBS7_TAP_A] ^ lfsr_q[PRBS7_TAP_B]};
        strobe_q <= 1'b1;
      end else begin
        cnt_q    <= cnt_q + 32'd1;
        strobe_q <= 1'b0;
      end
    end else begin
      strobe_q <= 1'b0;
    end
  end

  assign sym_bit_o    = lfsr_q[6];
  assign sym_strobe_o = strobe_q;

endmodule

// File: rtl/am_ask_modulator.sv
// Three-stage AM / ASK modulator producing offset-binary DAC samples:
// envelope select, full-precision multiply, then shift/clip/offset.
module am_ask_modulator
  import am_ask_modulator_pkg::*;
#(
  parameter int          CW      = 14,
  parameter int          MW      = 8,
  parameter int          DW      = 9,
  parameter int          OW      = 14,
  parameter int          SHIFT   = 8,
  parameter int unsigned SYM_DIV = 250000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [CW-1:0] carrier,
  input  logic [MW-1:0] message,
  input  logic [DW-1:0] depth,
  input  logic [1:0]    mode,
  input  logic          sym_en,
  output logic          out_valid,
  output logic [OW-1:0] am_out,
  output logic          sat,
  output logic          sym_bit,
  output logic          sym_strobe
);

  localparam int EW = ((MW > DW) ? MW : DW) + 2;
  localparam int PW = CW + EW;
  localparam logic signed [EW-1:0] PASS_ENV = EW'(2 ** SHIFT);
  localparam logic [OW-1:0]        MID      = OW'(midscale(OW));

  ask_symbol_gen #(.SYM_DIV(SYM_DIV)) u_symgen (
    .clk          (clk),
    .rst_n        (rst_n),
    .sym_en_i     (sym_en),
    .sym_bit_o    (sym_bit),
    .sym_strobe_o (sym_strobe)
  );

  logic signed [MW-1:0] msg_tc;
  logic signed [EW-1:0] msg_s, depth_s, env_d;
  assign msg_tc  = {~message[MW-1], message[MW-2:0]};
  assign msg_s   = {{(EW-MW){msg_tc[MW-1]}}, msg_tc};
  assign depth_s = {{(EW-DW){1'b0}}, depth};

  always_comb begin
    env_d = '0;
    case (mode_e'(mode))
      MODE_AM:   env_d = msg_s + depth_s;
      MODE_ASK:  env_d = sym_bit ? depth_s : '0;
      MODE_PASS: env_d = PASS_ENV;
      default:   env_d = '0;
    endcase
  end

  // stage 1 -> stage 2: envelope and carrier captured with the sample
  logic signed [CW-1:0] carrier_p0_q;
  logic signed [EW-1:0] env_p0_q;
  logic signed [PW-1:0] prod_d, prod_p1_q;
  logic                 vld_p0_q, vld_p1_q;

  assign prod_d = PW'(carrier_p0_q) * PW'(env_p0_q);

  always_ff @(posedge clk) begin
    carrier_p0_q <= carrier;
    env_p0_q     <= env_d;
    prod_p1_q    <= prod_d;
  end

  // stage 3: floor shift, clip, flip sign bit into offset binary
  logic signed [63:0] q_d, clip_d;
  logic [OW-1:0]      am_d;
  logic               sat_d;
  logic               out_valid_q, sat_q;
  logic [OW-1:0]      am_out_q;

  assign q_d    = 64'(prod_p1_q) >>> SHIFT;
  assign clip_d = clip_s(q_d, OW);
  assign sat_d  = (clip_d != q_d);
  assign am_d   = {~clip_d[OW-1], clip_d[OW-2:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0_q    <= 1'b0;
      vld_p1_q    <= 1'b0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      am_out_q    <= MID;
    end else begin
      vld_p0_q    <= in_valid;
      vld_p1_q    <= vld_p0_q;
      out_valid_q <= vld_p1_q;
      if (vld_p1_q) begin
        am_out_q <= am_d;
        sat_q    <= sat_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign am_out    = am_out_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_am_ask_modulator.sv
// Bench for am_ask_modulator: directed vector table, symbol/reset sequences,
// then randomized traffic against an arithmetic reference model.
module tb_am_ask_modulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [13:0] carrier;
  logic [7:0]  message;
  logic [8:0]  depth;
  logic [1:0]  mode;
  logic        sym_en;
  logic        out_valid;
  logic [13:0] am_out;
  logic        sat;
  logic        sym_bit;
  logic        sym_strobe;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  am_ask_modulator #(.SYM_DIV(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .carrier    (carrier),
    .message    (message),
    .depth      (depth),
    .mode       (mode),
    .sym_en     (sym_en),
    .out_valid  (out_valid),
    .am_out     (am_out),
    .sat        (sat),
    .sym_bit    (sym_bit),
    .sym_strobe (sym_strobe)
  );

  typedef struct {
    int mode;
    int c;
    int m;
    int d;
    int exp_out;
    bit exp_sat;
  } vec_t;

  vec_t tbl[10];
  int   prbs[400];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: envelope * carrier, floor divide by 256, clip to 14-bit signed, add offset
  function automatic void model(input int md, input int c, input int m, input int d,
                                input bit sb, output int o, output bit s);
    longint env, p, q;
    case (md)
      0:       env = m - 128 + d;
      1:       env = sb ? d : 0;
      2:       env = 256;
      default: env = 0;
    endcase
    p = longint'(c) * env;
    q = p >>> 8;
    s = 1'b0;
    if (q > 8191) begin q = 8191; s = 1'b1; end
    else if (q < -8192) begin q = -8192; s = 1'b1; end
    o = int'(q + 8192);
  endfunction

  task automatic drive(input bit v, input int md, input int c, input int m, input int d);
    in_valid = v;
    mode     = 2'(md);
    carrier  = 14'(c);
    message  = 8'(m);
    depth    = 9'(d);
  endtask

  initial begin
    int n;
    int strobes;
    int last_st;

    tbl[0] = '{0,  4096, 128, 180, 11072, 1'b0};
    tbl[1] = '{0, -4096, 128, 180,  5312, 1'b0};
    tbl[2] = '{0,  8191, 255, 180, 16383, 1'b1};
    tbl[3] = '{0, -8192, 255, 180,     0, 1'b1};
    tbl[4] = '{2,  -100,   0,   0,  8092, 1'b0};
    tbl[5] = '{3,  5000, 200, 300,  8192, 1'b0};
    tbl[6] = '{1,  1000,   0, 256,  9192, 1'b0};
    tbl[7] = '{0,   100,   0,   0,  8142, 1'b0};
    tbl[8] = '{2,  8191,   0,   0, 16383, 1'b0};
    tbl[9] = '{0,    -1, 129,   0,  8191, 1'b0};
    n = 10;

    // PRBS7 output sequence: seven ones, then b[k+7] = b[k] ^ b[k+1]
    for (int k = 0; k < 7; k++) prbs[k] = 1;
    for (int k = 7; k < 400; k++) prbs[k] = prbs[k-7] ^ prbs[k-6];

    rst_n  = 1'b0;
    sym_en = 1'b0;
    drive(1'b0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", out_valid, 0);
    chk("reset am_out", am_out, 8192);
    chk("reset sat", sat, 0);
    chk("reset sym_bit", sym_bit, 1);
    chk("reset sym_strobe", sym_strobe, 0);
    rst_n = 1'b1;

    // Directed table, back to back, one result per cycle three cycles later
    for (int t = 0; t < n + 4; t++) begin
      if (t >= 3 && t - 3 < n) begin
        chk("tbl out_valid", out_valid, 1);
        chk("tbl am_out", am_out, 64'(tbl[t-3].exp_out));
        chk("tbl sat", sat, 64'(tbl[t-3].exp_sat));
      end else if (t < 3 || t == n + 3) begin
        chk("tbl bubble out_valid", out_valid, 0);
      end
      if (t < n) drive(1'b1, tbl[t].mode, tbl[t].c, tbl[t].m, tbl[t].d);
      else       drive(1'b0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
    end
    chk("bubble hold am_out", am_out, 8191);

    // Symbol timer: strobes exactly every 4 enabled cycles, bit follows PRBS7
    sym_en  = 1'b1;
    strobes = 0;
    last_st = 0;
    for (int i = 1; i <= 44; i++) begin
      @(posedge clk);
      #1;
      if (sym_strobe) begin
        chk("strobe spacing", 64'(i - last_st), 4);
        last_st = i;
        strobes++;
        chk("sym_bit at strobe", sym_bit, 64'(prbs[strobes]));
      end
    end
    chk("strobe count", 64'(strobes), 11);
    chk("sym_bit after run", sym_bit, 64'(prbs[11]));

    // Reset with two samples in flight
    sym_en = 1'b0;
    drive(1'b1, 0, 4096, 128, 180);
    @(posedge clk);
    #1;
    drive(1'b1, 0, -4096, 128, 180);
    @(posedge clk);
    #1;
    drive(1'b0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst out_valid", out_valid, 0);
    chk("async rst am_out", am_out, 8192);
    chk("async rst sym_bit reseed", sym_bit, 1);
    chk("async rst sym_strobe", sym_strobe, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomized traffic against the model
    begin
      int  exp_o[$];
      bit  exp_v[$];
      bit  exp_s[$];
      int  en_before;
      bit  prev_en;
      int  last_out;
      bit  sb_exp, st_exp;
      int  md, c, m, d, o;
      bit  v, s;

      en_before = 0;
      prev_en   = 1'b0;
      last_out  = 8192;
      for (int t = 0; t < 1500; t++) begin
        sb_exp = prbs[en_before / 4][0];
        st_exp = prev_en && (en_before % 4 == 0);
        chk("rnd sym_bit", sym_bit, 64'(sb_exp));
        chk("rnd sym_strobe", sym_strobe, 64'(st_exp));
        if (t >= 3) begin
          chk("rnd out_valid", out_valid, 64'(exp_v[t-3]));
          if (exp_v[t-3]) begin
            chk("rnd am_out", am_out, 64'(exp_o[t-3]));
            chk("rnd sat", sat, 64'(exp_s[t-3]));
            last_out = exp_o[t-3];
          end else begin
            chk("rnd hold am_out", am_out, 64'(last_out));
          end
        end else begin
          chk("post-reset out_valid", out_valid, 0);
        end

        v  = ($urandom_range(0, 9) < 8);
        md = $urandom_range(0, 3);
        c  = $urandom_range(0, 16383) - 8192;
        m  = $urandom_range(0, 255);
        d  = $urandom_range(0, 511);
        sym_en = ($urandom_range(0, 9) < 7);
        drive(v, md, c, m, d);
        model(md, c, m, d, sb_exp, o, s);
        exp_v.push_back(v);
        exp_o.push_back(o);
        exp_s.push_back(s);
        prev_en = sym_en;
        if (sym_en) en_before++;
        @(posedge clk);
        #1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
